// File: rtl/uart_rx_core.sv
// UART receiver: 16x-oversampled deserialiser with optional parity and a
// valid/ack handoff carrying parity, framing and overrun status.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       HAS_PAR  = (PARITY_EN != 0);
    localparam logic       ODD      = (PARITY_ODD != 0);

    state_t                state, state_next;
    logic                  rx_meta, rxs;
    logic [3:0]            tcnt, tcnt_next;
    logic [2:0]            bcnt, bcnt_next;
    logic [DATA_BITS-1:0]  sr, sr_next;
    logic                  par, par_next;
    logic                  load, stop_low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= 4'd0;
            bcnt <= 3'd0;
            sr   <= '0;
            par  <= 1'b0;
        end else begin
            tcnt <= tcnt_next;
            bcnt <= bcnt_next;
            sr   <= sr_next;
            par  <= par_next;
        end
    end

    // tcnt wraps 15->0 on its own, so the DATA/PARITY/STOP sample points fall
    // every 16 ticks after the mid-start-bit check.
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        bcnt_next  = bcnt;
        sr_next    = sr;
        par_next   = par;
        load       = 1'b0;
        stop_low   = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    tcnt_next  = 4'd0;
                    par_next   = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd7) begin
                        tcnt_next  = 4'd0;
                        bcnt_next  = 3'd0;
                        state_next = rxs ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        sr_next = {rxs, sr[DATA_BITS-1:1]};
                        if (bcnt == LAST_BIT)
                            state_next = HAS_PAR ? PARITY : STOP;
                        else
                            bcnt_next = bcnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        par_next   = rxs ^ (^sr) ^ ODD;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    tcnt_next = tcnt + 4'd1;
                    if (tcnt == 4'd15) begin
                        if (rxs) begin
                            load       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            stop_low   = 1'b1;
                            state_next = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A load in the same cycle as rx_ack wins: the old word counts as consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= stop_low;
            overrun   <= 1'b0;
            busy      <= (state_next != IDLE);
            if (load) begin
                rx_data    <= sr;
                rx_valid   <= 1'b1;
                parity_err <= par & HAS_PAR;
                overrun    <= rx_valid & ~rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 instance and an 8E1 instance fed
// with directed frames; a monitor per instance pops expected words on delivery.
module tb_uart_rx_core;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic [1:0] div = 2'd0;
    int         cyc = 0;

    logic       rxd0 = 1'b1, rxd1 = 1'b1, ack0 = 1'b0, ack1 = 1'b0;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, parity_err0, parity_err1;
    logic       frame_err0, frame_err1, overrun0, overrun1, busy0, busy1;

    exp_t q0[$], q1[$];
    int   n_checks = 0, n_fail = 0;
    int   fe0 = 0, ov0 = 0, load_cyc0 = 0, start_cyc = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;
    logic [7:0] pd0 = 8'h00, pd1 = 8'h00;

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(ack0),
        .parity_err(parity_err0), .frame_err(frame_err0),
        .overrun(overrun0), .busy(busy0)
    );

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rxd(rxd1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ack(ack1),
        .parity_err(parity_err1), .frame_err(frame_err1),
        .overrun(overrun1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Baud tick every 4th clock, updated just after the edge like a registered source.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        div       <= div + 2'd1;
        baud_tick <= (div == 2'd3);
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && rx_valid0 && (!pv0 || rx_data0 != pd0 || overrun0)) begin
            load_cyc0 = cyc;
            if (q0.size() == 0) begin
                check_output("unexpected_word0", 32'(rx_data0), 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                check_output("word0_data", 32'(rx_data0), 32'(e.data));
                check_output("word0_perr", 32'(parity_err0), 32'(e.perr));
            end
        end
        pv0 = rx_valid0;
        pd0 = rx_data0;
        if (frame_err0) fe0++;
        if (overrun0) ov0++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && rx_valid1 && (!pv1 || rx_data1 != pd1 || overrun1)) begin
            if (q1.size() == 0) begin
                check_output("unexpected_word1", 32'(rx_data1), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check_output("word1_data", 32'(rx_data1), 32'(e.data));
                check_output("word1_perr", 32'(parity_err1), 32'(e.perr));
            end
        end
        pv1 = rx_valid1;
        pd1 = rx_data1;
    end

    task automatic push_exp(input int which, input logic [7:0] data, input logic perr);
        exp_t e;
        e.data = data;
        e.perr = perr;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic hold(input int which, input logic val, input int nbits);
        if (which == 0) rxd0 = val;
        else            rxd1 = val;
        repeat (nbits * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int which, input logic [7:0] data,
                                  input logic with_par, input logic par_bit,
                                  input logic stop_bit);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        hold(which, 1'b0, 1);
        for (int i = 0; i < 8; i++) hold(which, data[i], 1);
        if (with_par) hold(which, par_bit, 1);
        hold(which, stop_bit, 1);
    endtask

    task automatic pulse_ack(input int which);
        @(posedge clk);
        #1;
        if (which == 0) ack0 = 1'b1; else ack1 = 1'b1;
        @(posedge clk);
        #1;
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (which == 0) check_output("ack_clears_valid0", 32'(rx_valid0), 32'd0);
        else            check_output("ack_clears_valid1", 32'(rx_valid1), 32'd0);
    endtask

    // Raises ack0 for exactly the edge of the 152nd counted tick (stop sample, 8N1).
    task automatic ack_at_load();
        int n = 0;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 800 && n < 152; k++) begin
            if (baud_tick) n++;
            if (n == 152) begin
                ack0 = 1'b1;
                @(posedge clk);
                #1;
                ack0 = 1'b0;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        check_output("ack_load_tick_found", 32'(n), 32'd152);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fe_before, ov_before, lat;

        repeat (4) @(posedge clk);
        #1;
        check_output("reset_rx_data", 32'(rx_data0), 32'd0);
        check_output("reset_rx_valid", 32'(rx_valid0), 32'd0);
        check_output("reset_busy", 32'(busy0), 32'd0);
        check_output("reset_frame_err", 32'(frame_err0), 32'd0);
        check_output("reset_overrun", 32'(overrun0), 32'd0);
        check_output("reset_parity_err", 32'(parity_err0), 32'd0);
        rst = 1'b1;
        repeat (10) @(posedge clk);

        push_exp(0, 8'h55, 1'b0);
        apply_stimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
        lat = load_cyc0 - start_cyc;
        check_output("latency_in_range", 32'((lat >= 604 && lat <= 615) ? 1 : 0), 32'd1);
        pulse_ack(0);

        @(posedge clk);
        #1;
        rxd0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("false_start_busy_high", 32'(busy0), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rxd0 = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_output("false_start_busy_low", 32'(busy0), 32'd0);
        check_output("false_start_no_valid", 32'(rx_valid0), 32'd0);

        push_exp(1, 8'hA3, 1'b1);
        apply_stimulus(1, 8'hA3, 1'b1, 1'b1, 1'b1);
        pulse_ack(1);
        push_exp(1, 8'hA3, 1'b0);
        apply_stimulus(1, 8'hA3, 1'b1, 1'b0, 1'b1);
        pulse_ack(1);

        fe_before = fe0;
        apply_stimulus(0, 8'h81, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b0, 2);
        check_output("break_busy_high", 32'(busy0), 32'd1);
        check_output("break_no_valid", 32'(rx_valid0), 32'd0);
        check_output("frame_err_pulses", 32'(fe0 - fe_before), 32'd1);
        rxd0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_output("break_exit_busy_low", 32'(busy0), 32'd0);
        push_exp(0, 8'h3C, 1'b0);
        apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        pulse_ack(0);

        ov_before = ov0;
        push_exp(0, 8'h11, 1'b0);
        apply_stimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
        push_exp(0, 8'h22, 1'b0);
        apply_stimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
        check_output("overrun_pulses", 32'(ov0 - ov_before), 32'd1);
        pulse_ack(0);

        ov_before = ov0;
        push_exp(0, 8'h11, 1'b0);
        apply_stimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
        push_exp(0, 8'h22, 1'b0);
        fork
            apply_stimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
            ack_at_load();
        join
        check_output("ack_on_load_no_overrun", 32'(ov0 - ov_before), 32'd0);
        check_output("ack_on_load_valid_kept", 32'(rx_valid0), 32'd1);

        @(posedge clk);
        #1;
        hold(0, 1'b0, 1);
        hold(0, 1'b0, 3);
        repeat (32) @(posedge clk);
        #1;
        rst = 1'b0;
        rxd0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("midframe_reset_rx_data", 32'(rx_data0), 32'd0);
        check_output("midframe_reset_rx_valid", 32'(rx_valid0), 32'd0);
        check_output("midframe_reset_busy", 32'(busy0), 32'd0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        push_exp(0, 8'h0F, 1'b0);
        apply_stimulus(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        pulse_ack(0);

        repeat (20) @(posedge clk);
        #1;
        check_output("queue0_drained", 32'(q0.size()), 32'd0);
        check_output("queue1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive side of the UART. Consumes the 16x-oversampling tick strobe from the baud generator and deserialises the `rxd` line into parallel bytes. Frame format: one start bit, DATA_BITS data bits (LSB first), an optional parity bit, and one stop bit. Each received word is handed to the system side through a valid/ack handshake, with parity, framing and overrun status.

## Interface
- DATA_BITS, default 8: data bits per frame; legal values 5..8.
- PARITY_EN, default 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, default 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-clk strobe at 16x the baud rate, from the baud generator.
- rxd  input  1  serial line, asynchronous, idle high.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  high while rx_data holds an unacknowledged word.
- rx_ack  input  1  consumer strobe; clears rx_valid.
- parity_err  output  1  sticky with rx_valid: parity of the current rx_data was wrong.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- overrun  output  1  one-clk pulse when a new word lands while rx_valid=1.
- busy  output  1  high in any state other than IDLE.

## Operation
- rxd passes through a 2-FF synchroniser (rst value 1) to give rxs. All decisions use rxs.
- 4-bit tick counter tcnt advances only on baud_tick. 3-bit bit counter bcnt; shift register sr.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when rxs=0, go to START and set tcnt=0. baud_tick is not required to leave IDLE.
  - START: on the baud_tick where tcnt==7 (the 8th tick, mid start bit):
    - rxs=0: go to DATA, tcnt=0, bcnt=0.
    - rxs=1: false start, return to IDLE with no output.
  - DATA: on the baud_tick where tcnt==15, sample rxs into the MSB of sr and shift sr right. When bcnt==DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP; otherwise bcnt++. tcnt wraps 15->0.
  - PARITY: on tcnt==15, capture p = rxs XOR (XOR of sr) XOR PARITY_ODD. p=1 means error. Go to STOP.
  - STOP: on tcnt==15:
    - rxs=1: load rx_data=sr, set rx_valid=1, set parity_err=p (0 if PARITY_EN=0). If rx_valid was already 1, pulse overrun and overwrite rx_data. Go to IDLE.
    - rxs=0: pulse frame_err, leave rx_data, rx_valid and parity_err unchanged, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid and parity_err on the next clk.
  - rx_ack with rx_valid=0 is ignored.
  - If rx_ack and a word load occur in the same cycle, the load wins: rx_valid stays 1 and no overrun pulses (the old word counts as consumed).
- A baud_tick arriving while the FSM is in IDLE has no effect.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. FSM=IDLE, tcnt=0, bcnt=0, synchroniser=1.
- rst may assert at any time. It aborts any frame in progress immediately; no partial word is delivered.
- rxd to rxs: 2 clk latency.
- Sample points, counted from the first baud_tick after start detect: tick 8 (start), then ticks 24, 40, ..., 8+16k.
- rx_valid rises 1 clk after the stop-bit sample tick. frame_err and overrun are single-clk pulses at the same edge.
- busy drops on the same edge that rx_valid/frame_err asserts (entering IDLE), or on the edge leaving BREAK.
- All outputs are registered.

## Test plan
- Frame 0x55 at DATA_BITS=8, no parity, baud_tick every 4 clk -> rx_data=0x55, rx_valid=1 about 9.5 bit times (~608 clk) after the start edge; parity_err=0. Then rx_ack -> rx_valid=0 on the next clk.
- Low glitch on rxd for 5 ticks, then high -> false start: FSM returns to IDLE, rx_valid stays 0, busy low again after tick 8.
- PARITY_EN=1, PARITY_ODD=0, send 0xA3 with the parity bit wrong (1) -> rx_valid=1, rx_data=0xA3, parity_err=1. Same frame with correct parity (0) -> parity_err=0.
- Stop bit driven 0, line held low for 3 bit times -> one frame_err pulse, rx_valid stays 0, busy stays high until rxd returns high, then the next frame 0x3C is received correctly.
- Two frames 0x11 then 0x22 with no rx_ack -> overrun pulses once at the second stop sample, rx_data=0x22. Repeat with rx_ack coinciding with the load cycle -> no overrun pulse.
- Assert rst mid-DATA of frame 0xF0 -> all outputs at reset values. A following frame 0x0F is received intact.
